obstacle_generator: RTL and testbench

//   Producer of the two scrolling obstacle x-positions consumed by the player-side logic (AI controller, collision, renderer).

---
 rtl/obstacle_generator.sv | 141 ++++++++++++++
 tb/tb_obstacle_generator.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/obstacle_generator.sv
// Obstacle spawner/scroller: two obstacle slots moving left on each game_tick,
// LFSR-driven gap and sprite type, speed ramp, and an IDLE/RUN/CRASHED game state.
module obstacle_generator #(
   parameter int unsigned CONV       = 0,
   parameter int unsigned GEN_LINE   = 250,
   parameter int unsigned MIN_GAP    = 60,
   parameter int unsigned SPEED_INIT = 1,
   parameter int unsigned SPEED_MAX  = 4,
   parameter int unsigned SPEED_STEP = 256
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            game_tick,
   input  logic            crash,
   input  logic            button_up,
   output logic [9:CONV]   obstacle1_pos,
   output logic [9:CONV]   obstacle2_pos,
   output logic [1:0]      obstacle1_type,
   output logic [1:0]      obstacle2_type,
   output logic [2:0]      speed,
   output logic            game_active
);

   localparam int unsigned W  = 10 - CONV;
   localparam int unsigned FW = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;

   localparam logic [W-1:0]  GEN      = W'(GEN_LINE);
   localparam logic [W-1:0]  GAP_MIN  = W'(MIN_GAP);
   localparam logic [2:0]    SPD_INIT = 3'(SPEED_INIT);
   localparam logic [2:0]    SPD_MAX  = 3'(SPEED_MAX);
   localparam logic [FW-1:0] FRAME_TOP = FW'(SPEED_STEP - 1);
   localparam logic [15:0]   LFSR_SEED = 16'hACE1;

   typedef enum logic [1:0] {StIdle, StRun, StCrashed} state_e;

   state_e        state_q, state_d;
   logic [W-1:0]  pos1_q, pos1_d, pos2_q, pos2_d;
   logic [1:0]    type1_q, type1_d, type2_q, type2_d;
   logic [2:0]    speed_q, speed_d;
   logic [FW-1:0] frame_q, frame_d;
   logic [W-1:0]  gap_q, gap_d;
   logic [15:0]   lfsr_q, lfsr_d;

   logic [W-1:0]  spd_ext, thr;
   logic          spawn1, spawn2;

   // Saturating move: anything that would reach or pass 0 leaves the screen.
   function automatic logic [W-1:0] step_pos(input logic [W-1:0] p, input logic [W-1:0] s);
      return (p <= s) ? '0 : p - s;
   endfunction

   assign spd_ext = W'(speed_q);
   assign thr     = GEN - gap_q;
   assign spawn1  = (pos1_q == '0) && ((pos2_q == '0) || (pos2_q <= thr));
   assign spawn2  = !spawn1 && (pos2_q == '0) && (pos1_q <= thr);

   always_comb begin
      state_d = state_q;
      pos1_d  = pos1_q;
      pos2_d  = pos2_q;
      type1_d = type1_q;
      type2_d = type2_q;
      speed_d = speed_q;
      frame_d = frame_q;
      gap_d   = gap_q;
      lfsr_d  = lfsr_q;
      unique case (state_q)
         StIdle: begin
            if (button_up) state_d = StRun;
         end
         StRun: begin
            if (crash) begin
               state_d = StCrashed;
            end else if (game_tick) begin
               pos1_d = step_pos(pos1_q, spd_ext);
               pos2_d = step_pos(pos2_q, spd_ext);
               if (spawn1) begin
                  pos1_d  = GEN;
                  type1_d = lfsr_q[1:0];
                  gap_d   = GAP_MIN + W'(lfsr_q[7:2]);
               end else if (spawn2) begin
                  pos2_d  = GEN;
                  type2_d = lfsr_q[1:0];
                  gap_d   = GAP_MIN + W'(lfsr_q[7:2]);
               end
               // Galois form of x^16+x^14+x^13+x^11
               lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
               if (frame_q == FRAME_TOP) begin
                  frame_d = '0;
                  if (speed_q < SPD_MAX) speed_d = speed_q + 3'd1;
               end else begin
                  frame_d = frame_q + 1'b1;
               end
            end
         end
         StCrashed: begin
            if (button_up) begin
               state_d = StRun;
               pos1_d  = '0;
               pos2_d  = '0;
               speed_d = SPD_INIT;
               frame_d = '0;
               gap_d   = GAP_MIN;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         pos1_q  <= '0;
         pos2_q  <= '0;
         type1_q <= '0;
         type2_q <= '0;
         speed_q <= SPD_INIT;
         frame_q <= '0;
         gap_q   <= GAP_MIN;
         lfsr_q  <= LFSR_SEED;
      end else begin
         state_q <= state_d;
         pos1_q  <= pos1_d;
         pos2_q  <= pos2_d;
         type1_q <= type1_d;
         type2_q <= type2_d;
         speed_q <= speed_d;
         frame_q <= frame_d;
         gap_q   <= gap_d;
         lfsr_q  <= lfsr_d;
      end
   end

   assign obstacle1_pos  = pos1_q;
   assign obstacle2_pos  = pos2_q;
   assign obstacle1_type = type1_q;
   assign obstacle2_type = type2_q;
   assign speed          = speed_q;
   assign game_active    = (state_q == StRun);

endmodule

// File: tb/tb_obstacle_generator.sv
// Scoreboard bench for obstacle_generator: the driver pushes the model's expected
// post-edge outputs each cycle, an independent monitor pops and compares after the edge.
module tb_obstacle_generator;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       game_tick = 1'b0;
   logic       crash = 1'b0;
   logic       button_up = 1'b0;
   logic [9:0] obstacle1_pos, obstacle2_pos;
   logic [1:0] obstacle1_type, obstacle2_type;
   logic [2:0] speed;
   logic       game_active;

   obstacle_generator dut (
      .clk            (clk),
      .rst            (rst),
      .game_tick      (game_tick),
      .crash          (crash),
      .button_up      (button_up),
      .obstacle1_pos  (obstacle1_pos),
      .obstacle2_pos  (obstacle2_pos),
      .obstacle1_type (obstacle1_type),
      .obstacle2_type (obstacle2_type),
      .speed          (speed),
      .game_active    (game_active)
   );

   always #5 clk = ~clk;

   typedef struct {
      int p1, p2, t1, t2, spd, act;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model, game-level view
   localparam int GEN = 250, GAPMIN = 60, SINIT = 1, SMAX = 4, STEP = 256;
   int m_state;  // 0 idle, 1 run, 2 crashed
   int m_pos[2], m_type[2];
   int m_speed, m_frames, m_gap, m_lfsr;

   function automatic void model_reset();
      m_state = 0;
      m_pos[0] = 0; m_pos[1] = 0;
      m_type[0] = 0; m_type[1] = 0;
      m_speed = SINIT; m_frames = 0; m_gap = GAPMIN; m_lfsr = 'hACE1;
   endfunction

   function automatic void model_step(input bit t, input bit c, input bit b, input bit r);
      int old[2];
      int who;
      if (r) begin
         model_reset();
         return;
      end
      case (m_state)
         0: if (b) m_state = 1;
         1: begin
            if (c) m_state = 2;
            else if (t) begin
               old = m_pos;
               for (int i = 0; i < 2; i++) m_pos[i] = (old[i] > m_speed) ? old[i] - m_speed : 0;
               who = -1;
               for (int i = 0; i < 2; i++)
                  if (who < 0 && old[i] == 0 && (old[1-i] == 0 || old[1-i] <= GEN - m_gap))
                     who = i;
               if (who >= 0) begin
                  m_pos[who]  = GEN;
                  m_type[who] = m_lfsr % 4;
                  m_gap       = GAPMIN + (m_lfsr / 4) % 64;
               end
               if (m_lfsr % 2 == 1) m_lfsr = (m_lfsr / 2) ^ 'hB400;
               else m_lfsr = m_lfsr / 2;
               m_frames++;
               if (m_frames == STEP) begin
                  m_frames = 0;
                  if (m_speed < SMAX) m_speed++;
               end
            end
         end
         default: if (b) begin
            m_state = 1;
            m_pos[0] = 0; m_pos[1] = 0;
            m_speed = SINIT; m_frames = 0; m_gap = GAPMIN;
         end
      endcase
   endfunction

   task automatic cycle(input bit t, input bit c, input bit b, input bit r);
      exp_t e;
      @(negedge clk);
      game_tick = t; crash = c; button_up = b; rst = r;
      model_step(t, c, b, r);
      e.p1 = m_pos[0]; e.p2 = m_pos[1]; e.t1 = m_type[0]; e.t2 = m_type[1];
      e.spd = m_speed; e.act = (m_state == 1) ? 1 : 0;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
      end
   endtask

   // Monitor: outputs are registered, so every edge presents a new response.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("pos1", int'(obstacle1_pos), e.p1);
         chk("pos2", int'(obstacle2_pos), e.p2);
         chk("type1", int'(obstacle1_type), e.t1);
         chk("type2", int'(obstacle2_type), e.t2);
         chk("speed", int'(speed), e.spd);
         chk("active", int'(game_active), e.act);
      end
   end

   initial begin
      model_reset();
      // Reset, then idle ticks without button_up
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 1);
      repeat (5) cycle(1, 0, 0, 0);
      cycle(0, 1, 0, 0);
      // Start, first spawns and scrolling
      cycle(0, 0, 1, 0);
      repeat (300) cycle(($urandom_range(0, 1) == 1), 0, 0, 0);
      // Crash coincident with a tick, frozen field, restart with crash still high
      repeat (20) cycle(1, 0, 0, 0);
      cycle(1, 1, 0, 0);
      repeat (10) cycle(1, 0, 0, 0);
      cycle(1, 1, 1, 0);
      cycle(1, 0, 0, 0);
      repeat (40) cycle(1, 0, 0, 0);
      // Speed ramp to saturation over 2100 continuous ticks, then mid-run reset
      cycle(0, 0, 0, 1);
      cycle(0, 0, 1, 0);
      repeat (2100) cycle(1, 0, 0, 0);
      cycle(1, 0, 0, 1);
      cycle(1, 0, 0, 0);
      // Random mix of everything
      for (int i = 0; i < 3000; i++)
         cycle(($urandom_range(0, 2) != 0), ($urandom_range(0, 63) == 0),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 499) == 0));
      cycle(0, 0, 0, 0);
      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d responses left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
